// File: rtl/fifo_rd_pkg.sv
// Shared constants and state encoding for the FIFO demo read side.
// Also used by the writer and the FIFO IP wrapper so widths stay consistent.
package fifo_rd_pkg;

   localparam int unsigned FIFO_DW    = 8;
   localparam int unsigned FIFO_DEPTH = 256;
   localparam int unsigned FIFO_CNT_W = 16;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StDrain = 2'd1,
      StDone  = 2'd2
   } rd_state_e;

endpackage

// File: rtl/fifo_rd_checker.sv
// Ramp checker for the read controller: tracks the expected word and burst length,
// flags mismatches and keeps a saturating error count. Only built under FIFO_RD_CHECK_EN.
module fifo_rd_checker
   import fifo_rd_pkg::*;
#(
   parameter int unsigned DW    = FIFO_DW,
   parameter int unsigned DEPTH = FIFO_DEPTH,
   parameter int unsigned CNT_W = FIFO_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rd_valid,
   input  logic [DW-1:0]    rd_data,
   input  logic             burst_start,
   input  logic             burst_end,
   output logic             err_flag,
   output logic [CNT_W-1:0] err_cnt
);

   // One spare bit so an over-long burst can never alias back onto DEPTH.
   localparam int unsigned     WC_W     = $clog2(DEPTH + 1) + 1;
   localparam int unsigned     SUM_W    = CNT_W + 1;
   localparam logic [WC_W-1:0] WC_MAX   = '1;
   localparam logic [WC_W-1:0] DEPTH_WC = WC_W'(DEPTH);

   logic [DW-1:0]    exp_q;
   logic [WC_W-1:0]  word_cnt_q;
   logic             err_flag_q;
   logic [CNT_W-1:0] err_cnt_q;

   logic             data_err;
   logic             len_err;
   logic [1:0]       err_inc;
   logic [SUM_W-1:0] err_sum;
   logic [CNT_W-1:0] err_cnt_d;

   assign data_err = rd_valid && (rd_data != exp_q);
   assign len_err  = burst_end && (word_cnt_q != DEPTH_WC);

   always_comb begin
      err_inc   = {1'b0, data_err} + {1'b0, len_err};
      err_sum   = {1'b0, err_cnt_q} + SUM_W'(err_inc);
      err_cnt_d = err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         exp_q      <= '0;
         word_cnt_q <= '0;
         err_flag_q <= 1'b0;
         err_cnt_q  <= '0;
      end else begin
         if (burst_start) begin
            exp_q      <= '0;
            word_cnt_q <= '0;
         end else if (rd_valid) begin
            // No resync: a dropped word shifts every later comparison.
            exp_q <= exp_q + DW'(1);
            if (word_cnt_q != WC_MAX) begin
               word_cnt_q <= word_cnt_q + WC_W'(1);
            end
         end
         if (data_err || len_err) begin
            err_flag_q <= 1'b1;
            err_cnt_q  <= err_cnt_d;
         end
      end
   end

   assign err_flag = err_flag_q;
   assign err_cnt  = err_cnt_q;

endmodule

// File: rtl/fifo_rd.sv
// Read-side controller for the dual-port FIFO demo: waits for full, drains to empty in one burst.
// Data/length checking is present only when FIFO_RD_CHECK_EN is defined.
module fifo_rd
   import fifo_rd_pkg::*;
#(
   parameter int unsigned DW    = FIFO_DW,
   parameter int unsigned DEPTH = FIFO_DEPTH,
   parameter int unsigned CNT_W = FIFO_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rd_full,
   input  logic             rd_empty,
   input  logic [DW-1:0]    rd_data,
   output logic             rd_req,
   output logic             rd_valid,
   output logic             busy,
   output logic [CNT_W-1:0] burst_cnt,
   output logic             err_flag,
   output logic [CNT_W-1:0] err_cnt
);

   rd_state_e        state_q, state_d;
   logic             req_int;
   logic             burst_start;
   logic             burst_end;
   logic             rd_valid_q;
   logic [CNT_W-1:0] burst_cnt_q;

   always_comb begin
      state_d     = state_q;
      req_int     = 1'b0;
      burst_start = 1'b0;
      burst_end   = 1'b0;
      unique case (state_q)
         StIdle: begin
            // Full and empty together is illegal; hold off until flags make sense.
            if (rd_full && !rd_empty) begin
               state_d     = StDrain;
               burst_start = 1'b1;
            end
         end
         StDrain: begin
            req_int = 1'b1;
            if (rd_empty) begin
               state_d = StDone;
            end
         end
         StDone: begin
            // One extra cycle so the final word (read latency 1) is checked first.
            burst_end = 1'b1;
            state_d   = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         rd_valid_q  <= 1'b0;
         burst_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         rd_valid_q <= rd_req;
         if (burst_end) begin
            burst_cnt_q <= burst_cnt_q + CNT_W'(1);
         end
      end
   end

   assign rd_req    = req_int && !rd_empty;
   assign rd_valid  = rd_valid_q;
   assign busy      = (state_q == StDrain) || (state_q == StDone);
   assign burst_cnt = burst_cnt_q;

`ifdef FIFO_RD_CHECK_EN
   fifo_rd_checker #(
      .DW    (DW),
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) u_checker (
      .clk         (clk),
      .rst         (rst),
      .rd_valid    (rd_valid_q),
      .rd_data     (rd_data),
      .burst_start (burst_start),
      .burst_end   (burst_end),
      .err_flag    (err_flag),
      .err_cnt     (err_cnt)
   );
`else
   logic unused_chk;
   assign unused_chk = ^{rd_data, burst_start};
   assign err_flag   = 1'b0;
   assign err_cnt    = '0;
`endif

endmodule

// File: tb/tb_fifo_rd.sv
// Bench for fifo_rd: queue-based FIFO model plus a per-burst outcome model
// (words read, mismatches against the ramp, length errors, saturating error total).
module tb_fifo_rd;

   localparam int unsigned DW    = 8;
   localparam int unsigned DEPTH = 256;
   localparam int unsigned CNT_W = 16;
   localparam int          SAT   = (1 << CNT_W) - 1;

   logic             clk      = 1'b0;
   logic             rst      = 1'b1;
   logic             rd_full  = 1'b0;
   logic             rd_empty = 1'b1;
   logic [DW-1:0]    rd_data  = '0;
   logic             rd_req;
   logic             rd_valid;
   logic             busy;
   logic [CNT_W-1:0] burst_cnt;
   logic             err_flag;
   logic [CNT_W-1:0] err_cnt;

   always #5 clk = ~clk;

   fifo_rd #(
      .DW    (DW),
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .rd_full   (rd_full),
      .rd_empty  (rd_empty),
      .rd_data   (rd_data),
      .rd_req    (rd_req),
      .rd_valid  (rd_valid),
      .busy      (busy),
      .burst_cnt (burst_cnt),
      .err_flag  (err_flag),
      .err_cnt   (err_cnt)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // FIFO model: normal (non-show-ahead) mode, q registered one cycle after rd_req.
   logic [DW-1:0] fifo_q[$];
   bit force_full  = 1'b0;
   bit force_empty = 1'b0;

   always @(posedge clk) begin
      if (rd_req) begin
         check("no_read_when_empty", 32'(fifo_q.size() != 0), 32'd1);
         if (fifo_q.size() != 0) rd_data <= fifo_q.pop_front();
      end
      rd_empty <= force_empty || (fifo_q.size() == 0);
      rd_full  <= force_full || (fifo_q.size() == int'(DEPTH));
   end

   // Outcome model
   int exp_bursts = 0;
   int exp_err    = 0;
   bit exp_flag   = 1'b0;
   int burst_len  = 0;
   int burst_mism = 0;

   // Drain observations
   int n_req, n_valid, first_req, last_req, first_valid;

   task automatic load(input int len, input int nbad, input int fix_pos, input int fix_val);
      fifo_q.delete();
      for (int i = 0; i < len; i++) fifo_q.push_back(DW'(i));
      if (fix_pos >= 0) fifo_q[fix_pos] = DW'(fix_val);
      for (int k = 0; k < nbad; k++) begin
         int pos;
         pos = $urandom_range(0, len - 1);
         fifo_q[pos] = fifo_q[pos] ^ DW'($urandom_range(1, (1 << DW) - 1));
      end
      burst_len  = len;
      burst_mism = 0;
      for (int i = 0; i < len; i++) if (fifo_q[i] != DW'(i)) burst_mism++;
      force_full = (len != int'(DEPTH));
   endtask

   task automatic model_reset();
      exp_bursts = 0;
      exp_err    = 0;
      exp_flag   = 1'b0;
   endtask

   // Observe one burst at negedges; abort_at >= 0 pulses rst once that many reads are seen.
   task automatic drain(input int abort_at);
      bit seen;
      seen = 1'b0;
      n_req = 0; n_valid = 0; first_req = -1; last_req = -1; first_valid = -1;
      for (int cyc = 0; cyc < 3 * int'(DEPTH); cyc++) begin
         @(negedge clk);
         if (rst) begin
            rst = 1'b0;
            return;
         end
         if (rd_req) begin
            if (first_req < 0) first_req = cyc;
            last_req = cyc;
            n_req++;
         end
         if (rd_valid) begin
            if (first_valid < 0) first_valid = cyc;
            n_valid++;
         end
         if (busy) seen = 1'b1;
         if (abort_at >= 0 && n_req == abort_at) rst = 1'b1;
         else if (seen && !busy) return;
      end
      check("drain_timeout", 32'd0, 32'd1);
   endtask

   task automatic post_burst(input string tag);
      int errs;
      errs = burst_mism + ((burst_len != int'(DEPTH)) ? 1 : 0);
      exp_bursts++;
`ifdef FIFO_RD_CHECK_EN
      exp_err = exp_err + errs;
      if (exp_err > SAT) exp_err = SAT;
      if (errs != 0) exp_flag = 1'b1;
`endif
      force_full = 1'b0;
      check({tag, "_nreq"},      32'(n_req),                  32'(burst_len));
      check({tag, "_nvalid"},    32'(n_valid),                32'(burst_len));
      check({tag, "_b2b"},       32'(last_req - first_req + 1), 32'(burst_len));
      check({tag, "_vlat"},      32'(first_valid - first_req), 32'd1);
      check({tag, "_burst_cnt"}, 32'(burst_cnt),              32'(exp_bursts));
      check({tag, "_err_cnt"},   32'(err_cnt),                32'(exp_err));
      check({tag, "_err_flag"},  32'(err_flag),               32'(exp_flag));
      check({tag, "_idle"},      32'({busy, rd_req}),         32'd0);
   endtask

   initial begin
      // T1: reset held 3 cycles with a full FIFO
      rst = 1'b1;
      load(DEPTH, 0, -1, 0);
      repeat (3) @(negedge clk);
      check("t1_rd_req",    32'(rd_req),    32'd0);
      check("t1_rd_valid",  32'(rd_valid),  32'd0);
      check("t1_burst_cnt", 32'(burst_cnt), 32'd0);
      check("t1_err_cnt",   32'(err_cnt),   32'd0);
      check("t1_err_flag",  32'(err_flag),  32'd0);
      check("t1_busy",      32'(busy),      32'd0);
      model_reset();
      rst = 1'b0;

      // T2: clean burst straight out of reset; first rd_req one cycle after rst falls
      drain(-1);
      check("t1_req_latency", 32'(first_req), 32'd0);
      post_burst("t2");

      // T3: word 100 corrupted, then a clean burst
      @(negedge clk);
      load(DEPTH, 0, 100, 'hFF);
      drain(-1);
      post_burst("t3_bad");
      @(negedge clk);
      load(DEPTH, 0, -1, 0);
      drain(-1);
      post_burst("t3_clean");

      // T4: short burst of 200 words with full forced
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      load(200, 0, -1, 0);
      drain(-1);
      post_burst("t4");

      // T5: illegal full+empty holds IDLE
      @(negedge clk);
      load(DEPTH, 0, -1, 0);
      force_empty = 1'b1;
      repeat (4) begin
         @(negedge clk);
         check("t5_illegal_req",  32'(rd_req), 32'd0);
         check("t5_illegal_busy", 32'(busy),   32'd0);
      end
      force_empty = 1'b0;
      // Reset at word 50 abandons the burst with no error logged
      drain(50);
      model_reset();
      check("t5_abort_err_cnt",   32'(err_cnt),   32'd0);
      check("t5_abort_err_flag",  32'(err_flag),  32'd0);
      check("t5_abort_burst_cnt", 32'(burst_cnt), 32'd0);
      repeat (5) begin
         @(negedge clk);
         check("t5_wait_full", 32'({busy, rd_req}), 32'd0);
      end
      load(DEPTH, 0, -1, 0);
      drain(-1);
      post_burst("t5_next");

      // Randomized bursts: random length, corruption count and idle gaps
      for (int b = 0; b < 8; b++) begin
         int len;
         repeat ($urandom_range(1, 4)) @(negedge clk);
         len = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, DEPTH - 1)) : int'(DEPTH);
         load(len, int'($urandom_range(0, 3)), -1, 0);
         drain(-1);
         post_burst("rnd");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
